// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- fetch-side controller between the PC register, the
// instruction memory and the IF/ID boundary.
//
// Drives the PC register write port, issues one instruction-memory read per
// fetch (at most one in flight), applies branch/jump and exception
// redirects, squashes fetches made stale by a redirect, and buffers returned
// words in a two-entry queue (output slot plus skid) so that a decode stall
// never loses an instruction.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_cur                        current PC (PC register output)
//   pc_next, pc_wr_en             PC register write port (combinational)
//   imem_req, imem_addr           single-cycle read request (combinational)
//   imem_ack, imem_rdata          split-transaction read response
//   stall                         decode cannot accept this cycle
//   redirect_valid/_target        taken branch or jump
//   exc_valid                     exception, wins over redirect
//   if_valid, if_inst, if_pc      fetched instruction towards decode
//   fetch_fault                   sticky misaligned-PC flag
module pc_fetch_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_wr_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state_reg;
  logic        outstanding_reg;
  logic        squash_reg;
  logic [31:0] req_pc_reg;
  logic        skid_valid_reg;
  logic [31:0] skid_inst_reg;
  logic [31:0] skid_pc_reg;

  logic redirect;
  logic can_launch;
  logic launch;
  logic misaligned;
  logic ack_live;
  logic ack_take;
  logic consume;

  // BOOT is excluded so a redirect cannot land before the PC register settles.
  assign redirect   = ~rst & (state_reg != BOOT) & (exc_valid | redirect_valid);
  // A full skid blocks the next launch, which guarantees an ack always has room.
  assign can_launch = ~rst & (state_reg == RUN) & ~redirect &
                      ~outstanding_reg & ~skid_valid_reg;
  assign launch     = can_launch & (pc_cur[1:0] == 2'b00);
  assign misaligned = can_launch & (pc_cur[1:0] != 2'b00);

  // Acks with nothing in flight (stray or from before a reset) are ignored.
  assign ack_live = imem_ack & outstanding_reg;
  assign ack_take = ack_live & ~squash_reg;
  assign consume  = if_valid & ~stall;

  always_comb begin
    imem_req  = launch;
    imem_addr = launch ? pc_cur : 32'h0;
    pc_wr_en  = redirect | launch;
    pc_next   = 32'h0;
    if (redirect) begin
      pc_next = exc_valid ? EXC_VECTOR : redirect_target;
    end else if (launch) begin
      pc_next = pc_cur + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      outstanding_reg <= 1'b0;
      squash_reg      <= 1'b0;
      req_pc_reg      <= 32'h0;
      skid_valid_reg  <= 1'b0;
      skid_inst_reg   <= 32'h0;
      skid_pc_reg     <= 32'h0;
      if_valid        <= 1'b0;
      if_inst         <= 32'h0;
      if_pc           <= 32'h0;
      fetch_fault     <= 1'b0;
    end else begin
      if (state_reg == BOOT) begin
        state_reg <= RUN;
      end

      if (redirect) begin
        // Flush everything, including a held instruction under stall. An ack
        // arriving now is dropped; a fetch still in flight must be squashed.
        if_valid        <= 1'b0;
        skid_valid_reg  <= 1'b0;
        outstanding_reg <= outstanding_reg & ~imem_ack;
        squash_reg      <= outstanding_reg & ~imem_ack;
        state_reg       <= RUN;
        fetch_fault     <= 1'b0;
      end else begin
        if (ack_live) begin
          outstanding_reg <= 1'b0;
          squash_reg      <= 1'b0;
        end

        if (consume) begin
          if (skid_valid_reg) begin
            if_inst        <= skid_inst_reg;
            if_pc          <= skid_pc_reg;
            skid_valid_reg <= 1'b0;
          end else if (ack_take) begin
            if_inst <= imem_rdata;
            if_pc   <= req_pc_reg;
          end else begin
            if_valid <= 1'b0;
          end
        end else if (!if_valid) begin
          if (ack_take) begin
            if_valid <= 1'b1;
            if_inst  <= imem_rdata;
            if_pc    <= req_pc_reg;
          end
        end else if (ack_take) begin
          // Output slot is held by a stall: park the new word in the skid.
          skid_valid_reg <= 1'b1;
          skid_inst_reg  <= imem_rdata;
          skid_pc_reg    <= req_pc_reg;
        end

        if (launch) begin
          outstanding_reg <= 1'b1;
          req_pc_reg      <= pc_cur;
        end

        if (misaligned) begin
          state_reg   <= FAULT;
          fetch_fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: a PC register and a variable-latency memory
// surround the DUT; a transaction-level reference model (in-flight fetch plus
// a queue of fetched words) predicts every output each cycle.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h80000180;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_wr_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_fault;

  pc_fetch_ctrl #(.EXC_VECTOR(EXC_VEC)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_wr_en(pc_wr_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Memory: one pending response, delivered lat cycles after the request.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  int          mem_lat = 1;
  bit          rand_lat = 0;
  int          spur_pct = 0;

  // Reference model: mode 0=boot 1=run 2=fault.
  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} ent_t;
  ent_t        q[$];
  int          m_mode = 0;
  bit          m_infl = 0;
  bit          m_squash = 0;
  logic [31:0] m_iaddr = 0;
  bit          m_fault = 0;

  bit          saw_req;
  logic [31:0] first_req_addr;
  bit          first_req_seen = 0;

  task automatic step(input bit r, input bit s, input bit rv, input bit ex,
                      input logic [31:0] tgt);
    bit red, can, e_req, e_wr, ackv, d_wr;
    logic [31:0] e_next, d_next;
    rst = r; stall = s; redirect_valid = rv; exc_valid = ex; redirect_target = tgt;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(mem_addr);
        mem_pend = 0;
      end
    end else if ($urandom_range(0, 99) < spur_pct) begin
      imem_ack = 1'b1;
    end
    #4;
    red    = !r && m_mode != 0 && (rv || ex);
    can    = !r && m_mode == 1 && !red && !m_infl && q.size() < 2;
    e_req  = can && pc_cur[1:0] == 2'b00;
    e_wr   = red || e_req;
    e_next = red ? (ex ? EXC_VEC : tgt) : (e_req ? pc_cur + 32'd4 : 32'h0);
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, pc_cur);
    check("pc_wr_en", pc_wr_en, e_wr);
    if (e_wr || r || m_mode == 0) check("pc_next", pc_next, e_next);
    d_wr = pc_wr_en;
    d_next = pc_next;
    saw_req = imem_req;
    if (imem_req) begin
      mem_pend = 1;
      mem_cnt  = rand_lat ? $urandom_range(1, 4) : mem_lat;
      mem_addr = imem_addr;
      if (!first_req_seen) begin
        first_req_seen = 1;
        first_req_addr = imem_addr;
      end
    end
    // Model state update for this edge.
    ackv = imem_ack && m_infl;
    if (r) begin
      q.delete(); m_mode = 0; m_infl = 0; m_squash = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (red) begin
      q.delete();
      if (ackv) m_infl = 0;
      m_squash = m_infl;
      m_mode = 1;
      m_fault = 0;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (ackv) begin
        if (!m_squash) q.push_back('{inst: imem_rdata, pc: m_iaddr});
        m_infl = 0;
        m_squash = 0;
      end
      if (e_req) begin
        m_infl = 1; m_iaddr = pc_cur; m_squash = 0;
      end else if (can) begin
        m_mode = 2; m_fault = 1;
      end
    end
    @(posedge clk);
    #1;
    if (d_wr) pc_cur = d_next;
    check("if_valid", if_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("if_inst", if_inst, q[0].inst);
      check("if_pc", if_pc, q[0].pc);
    end
    check("fetch_fault", fetch_fault, m_fault);
  endtask

  task automatic run(input int n, input bit s);
    for (int i = 0; i < n; i++) step(0, s, 0, 0, 32'h0);
  endtask

  initial begin
    bit found;
    rst = 1; stall = 0; redirect_valid = 0; exc_valid = 0; redirect_target = 0;
    imem_ack = 0; imem_rdata = 0; pc_cur = 32'h00400000;
    @(posedge clk);
    #1;

    // Boot
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_valid", if_valid, 1'b0);
    pc_cur = 32'h00400000;
    mem_lat = 1;
    run(10, 0);
    check("boot_first_addr", first_req_addr, 32'h00400000);

    // Stall hold, then release
    run(6, 1);
    run(10, 0);

    // Squash with latency 3: redirect the cycle after a launch
    mem_lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 32'h0);
      found = saw_req;
    end
    check("squash_launch_seen", found, 1'b1);
    step(0, 0, 1, 0, 32'h00400100);
    run(12, 0);

    // Exception wins over redirect
    mem_lat = 1;
    step(0, 0, 1, 1, 32'h00400200);
    run(4, 0);

    // Misaligned target, then recovery
    step(0, 0, 1, 0, 32'h00400102);
    run(4, 0);
    step(0, 0, 1, 0, 32'h00400100);
    run(6, 0);

    // PC wrap
    step(0, 0, 1, 0, 32'hFFFFFFFC);
    run(4, 0);

    // Randomized traffic
    rand_lat = 1;
    spur_pct = 3;
    for (int i = 0; i < 4000; i++) begin
      bit r, s, rv, ex;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 99) < 35);
      rv = ($urandom_range(0, 99) < 4);
      ex = ($urandom_range(0, 99) < 1);
      tgt = 32'h00400000 + {20'h0, $urandom_range(0, 1023) * 4};
      if ($urandom_range(0, 9) < 2) tgt = tgt + $urandom_range(1, 3);
      else if ($urandom_range(0, 19) == 0) tgt = 32'hFFFFFFFC;
      step(r, s, rv, ex, tgt);
    end
    rand_lat = 0;
    spur_pct = 0;
    run(8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
